// File: rtl/fetch_queue.sv
// fetch_queue: byte-granular instruction prefetch queue.
// Fetches code bytes one at a time over a req/ack handshake into a circular
// buffer and presents a 7-byte window starting at the current EIP.
// Optional statistics counters are built when FETCH_QUEUE_STATS_EN is defined;
// otherwise stall_count/flush_count are tied to zero.
module fetch_queue #(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] RESET_EIP = 32'h0000_7c00
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [31:0]     mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic [6:0][7:0] memory_eip,
  output logic [31:0]     eip,
  output logic            window_valid,
  input  logic            consume,
  input  logic [2:0]      consume_len,
  input  logic            jump,
  input  logic [31:0]     jump_target,
  output logic [31:0]     stall_count,
  output logic [31:0]     flush_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [CW-1:0] WINDOW_CNT = CW'(7);

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] hd_q, hd_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   eip_q, eip_d;
  logic [31:0]   drop_addr_q, drop_addr_d;
  logic [7:0]    buf_q [DEPTH];
  logic [7:0]    buf_d [DEPTH];

  logic [31:0]   fetch_addr;
  logic [AW-1:0] wr_idx;
  logic          take;
  logic [CW-1:0] len_c;

  // Registered-state views: request, address and the decode window
  always_comb begin
    fetch_addr   = eip_q + {{(32-CW){1'b0}}, count_q};
    mem_req      = (state_q == ST_WAIT) || (state_q == ST_DROP);
    mem_addr     = (state_q == ST_DROP) ? drop_addr_q : fetch_addr;
    eip          = eip_q;
    window_valid = (count_q >= WINDOW_CNT);
    wr_idx       = hd_q + count_q[AW-1:0];
    for (int unsigned i = 0; i < 7; i++) begin
      memory_eip[i] = buf_q[hd_q + AW'(i)];
    end
  end

  // A consume is honoured only with a full window, a non-zero length and no jump
  always_comb begin
    len_c = CW'(consume_len);
    take  = consume && window_valid && (consume_len != 3'd0) && !jump;
  end

  // Next-state: fetch FSM, queue pointers, EIP and byte storage
  always_comb begin
    state_d     = state_q;
    hd_d        = hd_q;
    count_d     = count_q;
    eip_d       = eip_q;
    drop_addr_d = drop_addr_q;
    buf_d       = buf_q;

    if (jump) begin
      eip_d   = jump_target;
      count_d = '0;
      case (state_q)
        ST_FILL: state_d = ST_WAIT;
        // An unacked request keeps its address via DROP; an acked one is
        // simply discarded and the next request goes to the new target.
        ST_WAIT: begin
          if (!mem_ack) begin
            state_d     = ST_DROP;
            drop_addr_d = fetch_addr;
          end
        end
        // Stale request still outstanding: remain in DROP; if its ack lands
        // now it is retired and fetching restarts at the new target.
        ST_DROP: state_d = mem_ack ? ST_WAIT : ST_DROP;
        default: state_d = ST_FILL;
      endcase
    end else begin
      if ((state_q == ST_WAIT) && mem_ack) begin
        buf_d[wr_idx] = mem_rdata;
        count_d       = count_d + CW'(1);
      end
      if (take) begin
        hd_d    = hd_q + len_c[AW-1:0];
        eip_d   = eip_q + {{(32-CW){1'b0}}, len_c};
        count_d = count_d - len_c;
      end
      case (state_q)
        ST_FILL: if (count_d < FULL_CNT) state_d = ST_WAIT;
        ST_WAIT: if (count_d >= FULL_CNT) state_d = ST_FILL;
        ST_DROP: if (mem_ack) state_d = ST_WAIT;
        default: state_d = ST_FILL;
      endcase
    end
  end

  // State, pointer and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FILL;
      hd_q        <= '0;
      count_q     <= '0;
      eip_q       <= RESET_EIP;
      drop_addr_q <= RESET_EIP;
      buf_q       <= '{default: '0};
    end else begin
      state_q     <= state_d;
      hd_q        <= hd_d;
      count_q     <= count_d;
      eip_q       <= eip_d;
      drop_addr_q <= drop_addr_d;
      buf_q       <= buf_d;
    end
  end

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] flush_q, flush_d;

  // Statistics: cycles without a full window, and accepted jumps
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (!window_valid) stall_d = stall_q + 32'd1;
    if (jump)          flush_d = flush_q + 32'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed scenarios plus randomized traffic for fetch_queue,
// checked every cycle against a queue-based reference model. Memory returns
// addr[7:0] as data, so any wrongly kept or misplaced byte shows in the window.
module tb_fetch_queue;

  localparam int DEPTH = 16;
  localparam logic [31:0] RST_EIP = 32'h0000_7c00;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            mem_req;
  logic [31:0]     mem_addr;
  logic            mem_ack;
  logic [7:0]      mem_rdata;
  logic [6:0][7:0] memory_eip;
  logic [31:0]     eip;
  logic            window_valid;
  logic            consume = 1'b0;
  logic [2:0]      consume_len = 3'd0;
  logic            jump = 1'b0;
  logic [31:0]     jump_target = '0;
  logic [31:0]     stall_count;
  logic [31:0]     flush_count;
  logic            ack_now = 1'b0;

  assign mem_ack   = mem_req & ack_now;
  assign mem_rdata = mem_addr[7:0];

  fetch_queue #(.DEPTH(DEPTH), .RESET_EIP(RST_EIP)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .memory_eip(memory_eip), .eip(eip), .window_valid(window_valid),
    .consume(consume), .consume_len(consume_len),
    .jump(jump), .jump_target(jump_target),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: bytes held, EIP, request flag, and an outstanding
  // request that must be completed but whose data is to be thrown away.
  byte unsigned mq[$];
  logic [31:0]  m_eip;
  logic [31:0]  m_stale_addr;
  logic [31:0]  m_stall;
  logic [31:0]  m_flush;
  bit           m_req;
  bit           m_stale;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_addr();
    return m_stale ? m_stale_addr : (m_eip + 32'(mq.size()));
  endfunction

  task automatic model_reset();
    mq.delete();
    m_eip = RST_EIP; m_stale_addr = '0;
    m_stall = '0; m_flush = '0;
    m_req = 1'b0; m_stale = 1'b0;
  endtask

  function automatic logic [31:0] exp_stat(input logic [31:0] v);
`ifdef FETCH_QUEUE_STATS_EN
    return v;
`else
    return (v & 32'd0);
`endif
  endfunction

  task automatic check_reset();
    check("rst_req",   32'(mem_req), 32'd0);
    check("rst_addr",  mem_addr, RST_EIP);
    check("rst_eip",   eip, RST_EIP);
    check("rst_wv",    32'(window_valid), 32'd0);
    for (int i = 0; i < 7; i++) check($sformatf("rst_win%0d", i), 32'(memory_eip[i]), 32'd0);
    check("rst_stall", stall_count, 32'd0);
    check("rst_flush", flush_count, 32'd0);
  endtask

  task automatic check_outputs();
    check("req",  32'(mem_req), 32'(m_req));
    check("addr", mem_addr, m_addr());
    check("eip",  eip, m_eip);
    check("wv",   32'(window_valid), 32'(mq.size() >= 7));
    for (int i = 0; i < 7; i++)
      if (i < mq.size()) check($sformatf("win%0d", i), 32'(memory_eip[i]), 32'(mq[i]));
    check("stall", stall_count, exp_stat(m_stall));
    check("flush", flush_count, exp_stat(m_flush));
  endtask

  task automatic model_step(input bit c, input int l, input bit j, input logic [31:0] t, input bit a);
    bit          ack;
    int          sz;
    logic [31:0] ad;
    ack = m_req && a;
    sz  = mq.size();
    ad  = m_addr();
    if (sz < 7) m_stall++;
    if (j) begin
      m_flush++;
      if (m_req && !ack && !m_stale) begin
        m_stale = 1'b1; m_stale_addr = ad;
      end else if (ack) begin
        m_stale = 1'b0;
      end
      mq.delete();
      m_eip = t;
      m_req = 1'b1;
    end else begin
      if (ack) begin
        if (m_stale) m_stale = 1'b0;
        else mq.push_back(byte'(ad[7:0]));
      end
      if (c && l != 0 && sz >= 7) begin
        for (int k = 0; k < l; k++) void'(mq.pop_front());
        m_eip = m_eip + 32'(l);
      end
      m_req = m_stale || (mq.size() < DEPTH);
    end
  endtask

  // One clock cycle: check at negedge, drive, advance model, cross posedge.
  task automatic step(input bit c, input int l, input bit j, input logic [31:0] t, input bit a);
    check_outputs();
    consume = c; consume_len = 3'(l); jump = j; jump_target = t; ack_now = a;
    model_step(c, l, j, t, a);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset();
    rst_n = 1'b1;

    // Reset fill with zero-wait memory, then fill to full
    step(0, 0, 0, '0, 1);
    check("first_req", 32'(mem_req), 32'd1);
    check("first_addr", mem_addr, 32'h0000_7c00);
    for (int i = 0; i < 16; i++) step(0, 0, 0, '0, 1);
    check("full_req",  32'(mem_req), 32'd0);
    check("full_addr", mem_addr, 32'h0000_7c10);
    check("full_win6", 32'(memory_eip[6]), 32'h06);

    // Consume frees space; request reasserts at eip+count
    step(1, 3, 0, '0, 1);
    check("cons_eip",  eip, 32'h0000_7c03);
    check("cons_win0", 32'(memory_eip[0]), 32'h03);
    check("cons_req",  32'(mem_req), 32'd1);
    check("cons_addr", mem_addr, 32'h0000_7c10);

    // Simultaneous ack and consume at count 9
    step(1, 4, 0, '0, 0);
    step(1, 2, 0, '0, 1);
    check("ackcons_eip",  eip, 32'h0000_7c09);
    check("ackcons_addr", mem_addr, 32'h0000_7c11);

    // Jump during WAIT with a delayed ack
    step(0, 0, 0, '0, 0);
    step(0, 0, 1, 32'h0000_2000, 0);
    check("jmp_eip",  eip, 32'h0000_2000);
    check("jmp_addr", mem_addr, 32'h0000_7c11);
    check("jmp_wv",   32'(window_valid), 32'd0);
    step(0, 0, 0, '0, 0);
    step(0, 0, 0, '0, 1);
    check("jmp_newaddr", mem_addr, 32'h0000_2000);
    check("jmp_newreq",  32'(mem_req), 32'd1);
    check("jmp_flush",   flush_count, exp_stat(32'd1));

    // Address wrap
    step(0, 0, 1, 32'hffff_fffc, 1);
    for (int i = 0; i < 7; i++) step(0, 0, 0, '0, 1);
    check("wrap_eip",  eip, 32'hffff_fffc);
    check("wrap_win3", 32'(memory_eip[3]), 32'hff);
    check("wrap_win4", 32'(memory_eip[4]), 32'h00);
    check("wrap_addr", mem_addr, 32'h0000_0003);

    // Illegal consumes: zero length, then empty window
    step(1, 0, 0, '0, 0);
    check("ill_len0_eip", eip, 32'hffff_fffc);
    step(0, 0, 1, 32'h0000_3000, 0);
    step(1, 5, 0, '0, 1);
    check("ill_wv0_eip", eip, 32'h0000_3000);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit          c, j, a;
      int          l;
      logic [31:0] t;
      c = ($urandom_range(0, 9) < 4);
      l = $urandom_range(0, 7);
      j = ($urandom_range(0, 99) < 3);
      t = ($urandom_range(0, 3) == 0) ? (32'hffff_fff0 + 32'($urandom_range(0, 15))) : 32'($urandom);
      a = (n % 1000 < 300) ? 1'b1 : ($urandom_range(0, 2) == 0);
      step(c, l, j, t, a);
    end

    // Reset while a request is outstanding
    ack_now = 1'b0; consume = 1'b0; jump = 1'b0;
    check_outputs();
    #2 rst_n = 1'b0;
    #1 check_reset();
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) step(0, 0, 0, '0, 1);
    check_outputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Byte-granular instruction prefetch queue feeding the ModR/M and immediate decode stage. It fetches code bytes from memory one at a time over a request/acknowledge handshake and buffers them in a circular queue. It presents a 7-byte window starting at the current EIP as `memory_eip[6:0]`, with a valid flag. The execute stage retires 1–7 bytes per instruction through `consume`, or redirects fetch through `jump`.

## Interface
- `DEPTH`, 16, queue capacity in bytes; power of two, ≥ 8
- `RESET_EIP`, 32'h0000_7c00, EIP loaded at reset
- `clk` in 1, sole clock, rising edge
- `rst_n` in 1, asynchronous active-low reset
- `mem_req` out 1, fetch request; held until `mem_ack`
- `mem_addr` out 32, byte address of the request; stable while `mem_req` is high
- `mem_ack` in 1, `mem_rdata` is valid this cycle; completes the request
- `mem_rdata` in 8, fetched byte
- `memory_eip` out 8 × [6:0], `memory_eip[i]` = byte at `eip+i`
- `eip` out 32, address of `memory_eip[0]`
- `window_valid` out 1, all 7 window bytes present (count ≥ 7)
- `consume` in 1, retire `consume_len` bytes this cycle
- `consume_len` in 3, 1–7
- `jump` in 1, flush and redirect
- `jump_target` in 32, new EIP
- `stall_count` out 32, see Configuration
- `flush_count` out 32, see Configuration

## Operation
- **Storage:** circular byte array of `DEPTH` entries, head index `hd`, occupancy `count` (0..DEPTH). `memory_eip[i]` = `buf[(hd+i) mod DEPTH]`. This is combinational from registers. Bytes at or beyond `count` are don't-care.
- **Fetch address:** `mem_addr` = `eip + count`, modulo 2^32. Address wrap from FFFF_FFFF to 0 is silent.
- **FSM states:**
  - **FILL:** `mem_req` = 0. Go to WAIT when `count` < `DEPTH` after this cycle's updates.
  - **WAIT:** `mem_req` = 1. On `mem_ack`, write the byte at `(hd+count) mod DEPTH` and increment `count`. Stay in WAIT if space remains after the update; otherwise go to FILL.
  - **DROP:** `mem_req` = 1 at the stale address. On `mem_ack`, discard the byte and go to WAIT with the new address.
- **Consume:** when `consume` is high, `window_valid` = 1, and `consume_len` is 1–7:
  - `hd += consume_len`
  - `eip += consume_len`
  - `count -= consume_len`
- **Ignored consumes:** `consume` is ignored when `window_valid` = 0 or `consume_len` = 0.
- **Consume with ack:** when both happen in the same cycle, the net update is `count + 1 − consume_len`. `mem_addr` for the next request accounts for both.
- **Jump:** has priority over consume and is applied on the edge:
  - `eip` ← `jump_target`, `count` ← 0, `hd` unchanged.
  - If in WAIT with no ack this cycle, go to DROP.
  - If an ack arrives in the same cycle as the jump, discard the byte and go to WAIT at `jump_target`.
  - A jump while in DROP updates the target only; the FSM stays in DROP.
- **Held request:** `mem_addr` must not change while `mem_req` is high and unacknowledged, except via the DROP mechanism, where the stale address is held until ack.

## Timing
- **Reset values:**
  - `mem_req` = 0, `mem_addr` = `RESET_EIP`, `eip` = `RESET_EIP`
  - `count` = 0, `hd` = 0, `window_valid` = 0
  - all `memory_eip` bytes = 0 (storage cleared)
  - counters = 0, state = FILL
- **First request:** `mem_req` rises on the first edge after `rst_n` deasserts.
- **Zero-wait memory** (`mem_ack` asserted combinationally with `mem_req`):
  - Throughput is 1 byte per cycle.
  - `window_valid` rises on the edge after the 7th ack.
- **Window updates:** all outputs are visible on the edge following the event. `window_valid` reflects the registered `count`.
- **Full queue:** `mem_req` deasserts on the edge where `count` reaches `DEPTH`. It reasserts one cycle after a consume frees space.
- **Reset mid-request:** an outstanding request is abandoned. Memory must tolerate a request dropped without an ack.

## Configuration
- **`FETCH_QUEUE_STATS_EN` defined:**
  - `stall_count` increments every cycle in which `rst_n` = 1 and `window_valid` = 0.
  - `flush_count` increments on every accepted `jump`.
  - Both counters wrap at 2^32 and reset to 0.
- **Not defined:** both outputs are tied to 0 and no counter logic is built.

## Test plan
- **Reset fill:** release reset with zero-wait memory returning `mem_rdata` = `addr[7:0]`.
  - Expect `mem_addr` 7C00, 7C01, … on consecutive cycles.
  - `window_valid` = 1 after 7 acks, with `memory_eip[0..6]` = 00..06.
- **Fill to full:** `consume` held low.
  - Exactly 16 acks, then `mem_req` = 0 with `count` = 16.
  - Consume 3 → `eip` = 7C03, `memory_eip[0]` = 03, `mem_req` reasserts at 7C10.
- **Simultaneous ack and consume:** with `count` = 9, assert `consume_len` = 2 and `mem_ack` in the same cycle.
  - Expect `count` = 8 and next `mem_addr` = `eip_new` + 8.
- **Jump during WAIT:** with a 3-cycle ack delay, jump to 0000_2000 one cycle after `mem_req`.
  - `mem_addr` stays at the old address until ack, and that byte is discarded.
  - Next `mem_req` is at 0000_2000, `window_valid` = 0.
  - `flush_count` = 1 when `FETCH_QUEUE_STATS_EN` is defined.
- **Address wrap:** `jump_target` = FFFF_FFFC.
  - Fetch addresses are FFFF_FFFC..FFFF_FFFF, 0000_0000..0000_0002.
  - Window bytes are in order.
- **Illegal consume:** assert `consume` with `window_valid` = 0, or with `consume_len` = 0.
  - `eip` and `count` are unchanged.
